// File: rtl/mvm_par_stream.sv
// mvm_par_stream: y = A*x using P parallel MAC lanes, with a resident matrix and valid/ready load/result streams
module mvm_par_stream #(
    parameter int K    = 4,
    parameter int P    = 2,
    parameter int B    = 8,
    parameter int PIPE = 0,
    parameter int SAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadMatrix,
    input  logic                  loadVector,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [B-1:0]   data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [2*B-1:0] data_out,
    output logic                  busy,
    output logic                  done
);
    localparam int G  = K / P;
    localparam int L  = K + 2 + PIPE;
    localparam int KW = $clog2(K);
    localparam int PW = P > 1 ? $clog2(P) : 1;
    localparam int GW = G > 1 ? $clog2(G) : 1;
    localparam int AW = $clog2(G * K);
    localparam int CW = $clog2(L);
    localparam int SW = 2 * B + $clog2(K);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;

    state_t                state, state_d;
    logic                  a_ok, x_ok;
    logic [KW-1:0]         ld_r, ld_c, out_cnt;
    logic [PW-1:0]         ld_b;
    logic [GW-1:0]         ld_g, grp;
    logic [CW-1:0]         cyc;
    logic signed [B-1:0]   a_mem [P][G*K];
    logic signed [B-1:0]   x_mem [K];
    logic signed [B-1:0]   a_q [P];
    logic signed [B-1:0]   x_q;
    logic signed [2*B-1:0] prod [P];
    logic signed [2*B-1:0] prod_r [P];
    logic signed [2*B-1:0] term [P];
    logic signed [SW-1:0]  acc [P];
    logic signed [2*B-1:0] y [K];
    logic                  xfer, last_col, group_end, accum;

    assign s_ready   = state == LOAD_A || state == LOAD_X;
    assign xfer      = s_ready && s_valid;
    assign busy      = state != IDLE;
    assign m_valid   = state == OUTPUT;
    assign data_out  = m_valid ? y[out_cnt] : '0;
    assign last_col  = ld_c == KW'(K - 1);
    assign group_end = cyc == CW'(L - 1);
    // terms reach the accumulator one read latency (plus the optional product stage) after issue
    assign accum     = int'(cyc) >= 1 + PIPE && int'(cyc) <= K + PIPE;

    function automatic logic signed [2*B-1:0] wb(input logic signed [SW-1:0] v);
        logic ovf;
        ovf = !(&v[SW-1:2*B-1]) && |v[SW-1:2*B-1];
        return SAT != 0 && ovf ? {v[SW-1], {(2*B-1){!v[SW-1]}}} : v[2*B-1:0];
    endfunction

    always_comb begin
        state_d = state;
        case (state)
            IDLE:
                if (loadMatrix) state_d = LOAD_A;
                else if (loadVector) state_d = LOAD_X;
                else if (start && a_ok && x_ok) state_d = COMPUTE;
            LOAD_A:  if (xfer && last_col && ld_r == KW'(K - 1)) state_d = IDLE;
            LOAD_X:  if (xfer && last_col) state_d = IDLE;
            COMPUTE: if (group_end && grp == GW'(G - 1)) state_d = OUTPUT;
            OUTPUT:  if (m_ready && out_cnt == KW'(K - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_ok    <= 1'b0;
            x_ok    <= 1'b0;
            done    <= 1'b0;
            ld_r    <= '0;
            ld_c    <= '0;
            ld_b    <= '0;
            ld_g    <= '0;
            grp     <= '0;
            cyc     <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_d;
            done  <= state == OUTPUT && state_d == IDLE;
            if (state == LOAD_A && state_d == IDLE) a_ok <= 1'b1;
            if (state == LOAD_X && state_d == IDLE) x_ok <= 1'b1;
            if (xfer) begin
                ld_c <= last_col ? '0 : ld_c + 1'b1;
                if (state == LOAD_A && last_col) begin
                    ld_r <= ld_r == KW'(K - 1) ? '0 : ld_r + 1'b1;
                    ld_b <= ld_b == PW'(P - 1) ? '0 : ld_b + 1'b1;
                    if (ld_b == PW'(P - 1)) ld_g <= ld_g == GW'(G - 1) ? '0 : ld_g + 1'b1;
                end
            end
            if (state == COMPUTE) begin
                cyc <= group_end ? '0 : cyc + 1'b1;
                if (group_end) grp <= grp == GW'(G - 1) ? '0 : grp + 1'b1;
            end
            if (m_valid && m_ready) out_cnt <= out_cnt == KW'(K - 1) ? '0 : out_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l < P; l++) begin
            prod[l] = a_q[l] * x_q;
            term[l] = PIPE != 0 ? prod_r[l] : prod[l];
        end
    end

    // row r lives in bank r%P at (r/P)*K+c, so lane l of group g reads row g*P+l
    always_ff @(posedge clk) begin
        if (xfer && state == LOAD_A) a_mem[ld_b][AW'(int'(ld_g) * K + int'(ld_c))] <= data_in;
        if (xfer && state == LOAD_X) x_mem[ld_c] <= data_in;
        if (state == COMPUTE && int'(cyc) < K) begin
            x_q <= x_mem[KW'(cyc)];
            for (int l = 0; l < P; l++) a_q[l] <= a_mem[l][AW'(int'(grp) * K + int'(cyc))];
        end
        for (int l = 0; l < P; l++) begin
            prod_r[l] <= prod[l];
            if (cyc == '0) acc[l] <= '0;
            else if (accum) acc[l] <= acc[l] + {{(SW-2*B){term[l][2*B-1]}}, term[l]};
            if (state == COMPUTE && group_end) y[KW'(int'(grp) * P + l)] <= wb(acc[l]);
        end
    end
endmodule

// File: tb/tb_mvm_par_stream.sv
// tb_mvm_par_stream: directed scoreboard bench for three mvm_par_stream configurations sharing one stimulus
module tb_mvm_par_stream;
    logic clk = 1'b0, reset = 1'b1, loadMatrix = 1'b0, loadVector = 1'b0, start = 1'b0;
    logic s_valid = 1'b0, m_ready = 1'b1;
    logic signed [7:0] data_in = '0;
    logic [2:0] sr, mv, bz, dn;
    logic signed [15:0] d0, d1, d2;
    logic signed [15:0] q0[$], q1[$], q2[$];
    logic signed [7:0] am [4][4];
    logic signed [7:0] xv [4];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mvm_par_stream u0 (.clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .s_valid(s_valid), .s_ready(sr[0]), .data_in(data_in), .m_valid(mv[0]),
        .m_ready(m_ready), .data_out(d0), .busy(bz[0]), .done(dn[0]));
    mvm_par_stream #(.SAT(0)) u1 (.clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .s_valid(s_valid), .s_ready(sr[1]), .data_in(data_in), .m_valid(mv[1]),
        .m_ready(m_ready), .data_out(d1), .busy(bz[1]), .done(dn[1]));
    mvm_par_stream #(.P(1), .PIPE(1)) u2 (.clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
        .start(start), .s_valid(s_valid), .s_ready(sr[2]), .data_in(data_in), .m_valid(mv[2]),
        .m_ready(m_ready), .data_out(d2), .busy(bz[2]), .done(dn[2]));

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dot(int r);
        int s = 0;
        for (int c = 0; c < 4; c++) s += int'(am[r][c]) * int'(xv[c]);
        return s;
    endfunction

    function automatic logic signed [15:0] sat16(int v);
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
    endfunction

    always @(negedge clk) begin
        if (mv[0]) begin
            check("u0_beat_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                check("u0_data", d0, q0[0]);
                if (m_ready) void'(q0.pop_front());
            end
        end
        if (mv[1]) begin
            check("u1_beat_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                check("u1_data", d1, q1[0]);
                if (m_ready) void'(q1.pop_front());
            end
        end
        if (mv[2]) begin
            check("u2_beat_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                check("u2_data", d2, q2[0]);
                if (m_ready) void'(q2.pop_front());
            end
        end
    end

    task automatic load_a(input bit gap, input bit also_start);
        loadMatrix = 1'b1;
        start = also_start;
        tick();
        loadMatrix = 1'b0;
        start = 1'b0;
        check("srdy_load_a", sr, 3'b111);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (gap && c == 2) begin
                    s_valid = 1'b0;
                    tick();
                end
                s_valid = 1'b1;
                data_in = am[r][c];
                tick();
            end
        s_valid = 1'b0;
        data_in = '0;
        @(negedge clk);
        check("srdy_after_load_a", sr, 0);
        check("busy_after_load_a", bz, 0);
    endtask

    task automatic load_x(input bit gap);
        loadVector = 1'b1;
        tick();
        loadVector = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (gap && c == 1) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            data_in = xv[c];
            tick();
        end
        s_valid = 1'b0;
        data_in = '0;
        @(negedge clk);
        check("srdy_after_load_x", sr, 0);
    endtask

    task automatic run(input bit bp, input bit cmd_mid);
        int f0 = 0, f2 = 0, h0 = 0, h4 = 0, d0c = 0, d2c = 0, st = 0, nd = 0;
        for (int r = 0; r < 4; r++) begin
            q0.push_back(sat16(dot(r)));
            q1.push_back(16'(dot(r)));
            q2.push_back(sat16(dot(r)));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 80 && !(d0c != 0 && d2c != 0); k++) begin
            m_ready = !(bp && h0 == 1 && st < 3);
            loadMatrix = cmd_mid && k == 3;
            @(negedge clk);
            if (k == 1) check("busy_in_compute", bz, 3'b111);
            if (cmd_mid && k == 4) check("srdy_after_mid_cmd", sr, 0);
            if (mv[0] && f0 == 0) f0 = k;
            if (mv[2] && f2 == 0) f2 = k;
            if (mv[0] && !m_ready) st++;
            if (mv[0] && m_ready) begin
                h0++;
                if (h0 == 4) h4 = k;
            end
            if (dn[0]) begin
                nd++;
                if (d0c == 0) begin
                    d0c = k;
                    check("u0_busy_at_done", bz[0], 0);
                end
            end
            if (dn[2] && d2c == 0) d2c = k;
            @(posedge clk);
            #1;
        end
        loadMatrix = 1'b0;
        m_ready = 1'b1;
        check("u0_first_valid", f0, 13);
        check("u2_first_valid", f2, 29);
        check("u0_done_after_last", d0c, h4 + 1);
        check("u0_done_pulses", nd, 1);
        check("u0_stall_cycles", st, bp ? 3 : 0);
        check("u0_queue_drained", q0.size(), 0);
        check("u1_queue_drained", q1.size(), 0);
        check("u2_queue_drained", q2.size(), 0);
        check("idle_after_run", bz, 0);
    endtask

    initial begin
        repeat (2) tick();
        @(negedge clk);
        check("rst_s_ready", sr, 0);
        check("rst_m_valid", mv, 0);
        check("rst_busy", bz, 0);
        check("rst_done", dn, 0);
        check("rst_data_out", d0, 0);
        tick();
        reset = 1'b0;

        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_unloaded_busy", bz, 0);
        s_valid = 1'b1;
        data_in = 8'sd5;
        @(negedge clk);
        check("srdy_idle_with_valid", sr, 0);
        tick();
        s_valid = 1'b0;

        for (int r = 0; r < 4; r++) begin
            xv[r] = 8'(r + 1);
            for (int c = 0; c < 4; c++) am[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        end
        load_a(1'b0, 1'b0);
        load_x(1'b1);
        run(1'b0, 1'b0);

        load_a(1'b1, 1'b1);
        run(1'b0, 1'b1);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) am[r][c] = 8'((r * 4 + c) * 9 - 60);
        load_a(1'b0, 1'b0);
        xv[0] = 8'sd1; xv[1] = 8'sd0; xv[2] = 8'sd0; xv[3] = 8'sd0;
        load_x(1'b0);
        run(1'b0, 1'b0);
        xv[0] = 8'sd0; xv[3] = 8'sd1;
        load_x(1'b0);
        run(1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            xv[r] = 8'sd1;
            for (int c = 0; c < 4; c++) am[r][c] = 8'(r + 1);
        end
        load_a(1'b0, 1'b0);
        load_x(1'b0);
        run(1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            xv[r] = -8'sd128;
            for (int c = 0; c < 4; c++) am[r][c] = -8'sd128;
        end
        load_a(1'b0, 1'b0);
        load_x(1'b0);
        run(1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            xv[r] = 8'sd127;
            for (int c = 0; c < 4; c++) am[r][c] = 8'sd127;
        end
        load_a(1'b0, 1'b0);
        load_x(1'b0);
        run(1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", bz, 0);
        check("abort_m_valid", mv, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_after_reset_busy", bz, 0);
        load_a(1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_without_x_busy", bz, 0);
        load_x(1'b0);
        run(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
